// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the uart_tx side of uart_tx_arbiter.
// Signal names keep their i_/o_ prefixes as seen from the arbiter.
//   master : requesters + uart_tx (drive valid/data/busy)
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ*8-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 o_tx_start;
  logic [7:0]           o_tx_data;
  logic                 i_tx_busy;
  logic [GW-1:0]        o_grant_id;
  logic                 o_active;
  logic                 o_timeout;

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_tx_busy,
    input  o_req_ready,
    input  o_tx_start,
    input  o_tx_data,
    input  o_grant_id,
    input  o_active,
    input  o_timeout
  );

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_tx_busy,
    output o_req_ready,
    output o_tx_start,
    output o_tx_data,
    output o_grant_id,
    output o_active,
    output o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ byte requesters with round-robin
// priority. A grant in IDLE registers the byte, pulses o_tx_start for one
// cycle, then waits for the UART to raise and drop i_tx_busy.
//
// Reset: i_rst_n is synchronous and ACTIVE-HIGH (1 = reset) despite its name.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a byte when the
// UART never raises i_tx_busy; o_timeout then pulses TIMEOUT_CYC cycles after
// the start pulse and arbitration resumes from the dropped requester.
// Without the macro WAIT_BUSY waits forever and o_timeout is tied low.
// TIMEOUT_CYC must be at least 2 when the feature is enabled.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int            GW       = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [GW-1:0]        last_grant_r;
  logic [GW-1:0]        grant_id_r;
  logic [GW-1:0]        grant_s;
  logic                 found_s;
  logic                 take_s;
  logic [7:0]           sel_data_s;
  logic [7:0]           tx_data_r;
  logic                 tx_start_r;
  logic                 active_r;
  logic [NUM_REQ-1:0]   ready_s;
  logic                 tmo_hit_s;

`ifdef UART_ARB_TIMEOUT_EN
  // The counter only has to count up to TIMEOUT_CYC-2 (see tmo_hit_s).
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] tmo_cnt_r;
  logic          timeout_r;

  // The counter holds TIMEOUT_CYC-2 on the edge where it would reach
  // TIMEOUT_CYC-1; acting on that edge puts the registered o_timeout pulse
  // exactly TIMEOUT_CYC cycles after the o_tx_start pulse.
  assign tmo_hit_s = (state_r == ST_WAIT_BUSY) && !bus.i_tx_busy &&
                     (tmo_cnt_r == CW'(TIMEOUT_CYC - 2));

  // Start-timeout counter: zero outside WAIT_BUSY, counts while waiting there
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      tmo_cnt_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= tmo_hit_s;
      if (state_r == ST_WAIT_BUSY) begin
        tmo_cnt_r <= tmo_cnt_r + CW'(1);
      end else begin
        tmo_cnt_r <= '0;
      end
    end
  end

  assign bus.o_timeout = timeout_r;
`else
  // No watchdog: WAIT_BUSY waits as long as the UART needs.
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

  assign tmo_hit_s     = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // Round-robin pick: the valid requester nearest after last_grant_r, with wrap
  always_comb begin
    int dist_v;
    int best_v;
    dist_v     = 0;
    best_v     = NUM_REQ;
    found_s    = 1'b0;
    grant_s    = last_grant_r;
    sel_data_s = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      dist_v = k - int'(last_grant_r) - 1;
      if (dist_v < 0) begin
        dist_v = dist_v + NUM_REQ;
      end else begin
        dist_v = dist_v;
      end
      if (bus.i_req_valid[k] && (dist_v < best_v)) begin
        best_v     = dist_v;
        found_s    = 1'b1;
        grant_s    = GW'(k);
        sel_data_s = bus.i_req_data[8*k +: 8];
      end else begin
        best_v = best_v;
      end
    end
  end

  // Next-state logic; a grant is only taken from IDLE with the UART idle
  // and never while reset is held, so no byte is accepted during reset
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && !bus.i_tx_busy && !i_rst_n) begin
          take_s  = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // The accept strobe is the one combinational output: it has to appear in
  // the same cycle the requester is picked
  always_comb begin
    if (take_s) begin
      ready_s = ONE_HOT0 << grant_s;
    end else begin
      ready_s = '0;
    end
  end

  // State, grant bookkeeping and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_r      <= ST_IDLE;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      grant_id_r   <= '0;
      last_grant_r <= LAST_IDX;
      active_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= take_s;
      active_r   <= (state_s != ST_IDLE);
      if (take_s) begin
        tx_data_r    <= sel_data_s;
        grant_id_r   <= grant_s;
        last_grant_r <= grant_s;
      end else begin
        tx_data_r    <= tx_data_r;
        grant_id_r   <= grant_id_r;
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign bus.o_req_ready = ready_s;
  assign bus.o_tx_start  = tx_start_r;
  assign bus.o_tx_data   = tx_data_r;
  assign bus.o_grant_id  = grant_id_r;
  assign bus.o_active    = active_r;

endmodule
